// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants and types for the MIPS instruction fetch stage.
// NOP encoding, text-segment defaults, word size and the RUN/FAULT state type.
package instruction_fetch_stage_pkg;

    localparam logic [31:0] NOP               = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;
    localparam int          WORD_BYTES        = 4;

    // FAULT is only left through reset.
    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_stage_pipeline_register.sv
// Generic pipeline register with load enable and synchronous clear.
// Both reset and clear load RESET_VALUE; clear wins over enable.
module pipeline_register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= RESET_VALUE;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, drives the combinational program memory and fills IF/ID.
// Handles stall, flush, redirect and a sticky fault on illegal fetch addresses.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 51,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(DEFAULT_TEXT_BASE),
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic [DATA_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0] imem_instruction,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] if_id_instruction,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic                  fetch_fault
);

    localparam logic [DATA_WIDTH-1:0] TEXT_BYTES = DATA_WIDTH'(MEMORY_DEPTH * WORD_BYTES);
    localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(WORD_BYTES);

    fetch_state_t          state;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] pc_next;
    logic                  pc_invalid;
    logic                  pc_enable;
    logic                  if_id_enable;
    logic                  if_id_clear;
    logic                  fault_set;

    // The unsigned offset makes a PC below TEXT_BASE wrap to a huge value and fail the bound.
    always_comb begin
        imem_address = pc - TEXT_BASE;
        pc_plus4     = pc + STEP;
        pc_invalid   = (pc[1:0] != 2'b00) || (imem_address >= TEXT_BYTES);
    end

    always_comb begin
        pc_enable    = 1'b0;
        pc_next      = pc_plus4;
        if_id_enable = 1'b0;
        if_id_clear  = 1'b0;
        fault_set    = 1'b0;
        if (state == FAULT) begin
            if_id_clear = 1'b1;
        end else if (redirect_valid) begin
            pc_enable   = 1'b1;
            pc_next     = redirect_target;
            if_id_clear = 1'b1;
        end else if (pc_invalid) begin
            fault_set   = 1'b1;
            if_id_clear = 1'b1;
        end else if (stall) begin
            if_id_clear = flush;
        end else if (flush) begin
            pc_enable   = 1'b1;
            if_id_clear = 1'b1;
        end else begin
            pc_enable    = 1'b1;
            if_id_enable = 1'b1;
        end
    end

    pipeline_register #(.WIDTH(DATA_WIDTH), .RESET_VALUE(RESET_PC)) u_pc (
        .clk(clk), .reset(reset), .enable(pc_enable), .clear(1'b0),
        .d(pc_next), .q(pc)
    );

    pipeline_register #(.WIDTH(DATA_WIDTH), .RESET_VALUE(DATA_WIDTH'(NOP))) u_if_id_instruction (
        .clk(clk), .reset(reset), .enable(if_id_enable), .clear(if_id_clear),
        .d(imem_instruction), .q(if_id_instruction)
    );

    pipeline_register #(.WIDTH(DATA_WIDTH), .RESET_VALUE('0)) u_if_id_pc_plus4 (
        .clk(clk), .reset(reset), .enable(if_id_enable), .clear(if_id_clear),
        .d(pc_plus4), .q(if_id_pc_plus4)
    );

    pipeline_register #(.WIDTH(1), .RESET_VALUE(1'b0)) u_if_id_valid (
        .clk(clk), .reset(reset), .enable(if_id_enable), .clear(if_id_clear),
        .d(1'b1), .q(if_id_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (fault_set) state <= FAULT;
                FAULT:   state <= FAULT;
                default: state <= RUN;
            endcase
        end
    end

    assign fetch_fault = (state == FAULT);

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: an abstract next-state model is checked
// after every edge, plus literal expectations taken from the hand-worked fetch sequences.
module tb_instruction_fetch_stage;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 51;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] pc;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_fault;

    logic [31:0] rom [DEPTH];

    int n_vec = 0;
    int n_bad = 0;

    // model state: what IF must look like after each edge
    logic [31:0] m_pc, m_ins, m_pp4;
    logic        m_valid, m_fault;

    instruction_fetch_stage #(
        .DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .TEXT_BASE(BASE), .RESET_PC(BASE)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_address(imem_address), .imem_instruction(imem_instruction),
        .pc(pc), .if_id_instruction(if_id_instruction), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // combinational program memory, word indexed
    always_comb begin
        if ((imem_address >> 2) < DEPTH) imem_instruction = rom[imem_address >> 2];
        else                             imem_instruction = 32'hFFFF_FFFF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the priority rules, compare after the edge.
    task automatic cycle(input logic r, input logic s, input logic f,
                         input logic rv, input logic [31:0] rt);
        logic [31:0] off;
        logic        bad_pc;
        logic [31:0] n_pc, n_ins, n_pp4;
        logic        n_valid, n_fault;
        reset = r; stall = s; flush = f; redirect_valid = rv; redirect_target = rt;
        off    = m_pc - BASE;
        bad_pc = (m_pc % 4 != 0) || (off >= DEPTH * 4);
        n_pc = m_pc; n_ins = m_ins; n_pp4 = m_pp4; n_valid = m_valid; n_fault = m_fault;
        if (r) begin
            n_pc = BASE; n_ins = 0; n_pp4 = 0; n_valid = 0; n_fault = 0;
        end else if (m_fault) begin
            n_ins = 0; n_pp4 = 0; n_valid = 0;
        end else if (rv) begin
            n_pc = rt; n_ins = 0; n_pp4 = 0; n_valid = 0;
        end else if (bad_pc) begin
            n_fault = 1; n_ins = 0; n_pp4 = 0; n_valid = 0;
        end else if (s) begin
            if (f) begin n_ins = 0; n_pp4 = 0; n_valid = 0; end
        end else if (f) begin
            n_pc = m_pc + 4; n_ins = 0; n_pp4 = 0; n_valid = 0;
        end else begin
            n_ins = rom[off / 4]; n_pp4 = m_pc + 4; n_valid = 1; n_pc = m_pc + 4;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_ins = n_ins; m_pp4 = n_pp4; m_valid = n_valid; m_fault = n_fault;
        check("pc", pc, m_pc);
        check("imem_address", imem_address, m_pc - BASE);
        check("if_id_instruction", if_id_instruction, m_ins);
        check("if_id_pc_plus4", if_id_pc_plus4, m_pp4);
        check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'h2400_0000 | i;
        rom[0] = 32'h2008_0005;
        rom[1] = 32'h2009_0003;
        rom[2] = 32'h0109_5020;
        m_pc = 0; m_ins = 0; m_pp4 = 0; m_valid = 0; m_fault = 0;

        // reset
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("lit_reset_pc", pc, 32'h0040_0000);
        check("lit_reset_valid", {31'b0, if_id_valid}, 32'h0);

        // straight-line fetch of words 0 and 1
        run(1);
        check("lit_ins0", if_id_instruction, 32'h2008_0005);
        check("lit_pp4_0", if_id_pc_plus4, 32'h0040_0004);
        run(1);
        check("lit_ins1", if_id_instruction, 32'h2009_0003);
        check("lit_pc2", pc, 32'h0040_0008);

        // two stall cycles at 0x00400008, then resume
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("lit_stall_pc", pc, 32'h0040_0008);
        check("lit_stall_ins", if_id_instruction, 32'h2009_0003);
        run(1);
        check("lit_ins2", if_id_instruction, 32'h0109_5020);
        check("lit_pp4_2", if_id_pc_plus4, 32'h0040_000C);

        // redirect wins over stall
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0020);
        check("lit_redir_pc", pc, 32'h0040_0020);
        check("lit_redir_valid", {31'b0, if_id_valid}, 32'h0);
        run(1);
        check("lit_word8", if_id_instruction, 32'h2400_0008);

        // flush alone at 0x00400004
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0004);
        run(1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("lit_flush_pc", pc, 32'h0040_000C);
        check("lit_flush_ins", if_id_instruction, 32'h0);
        // stall with flush: pc holds, bubble
        run(1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("lit_stall_flush_pc", pc, 32'h0040_0010);
        run(2);

        // misaligned redirect: fault one edge later, then frozen despite redirects
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0002);
        check("lit_mis_pc", pc, 32'h0040_0002);
        check("lit_mis_nofault", {31'b0, fetch_fault}, 32'h0);
        run(1);
        check("lit_mis_fault", {31'b0, fetch_fault}, 32'h1);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'(i % 2), 1'b0, 1'b1, 32'h0040_0000 + 32'(4 * i));
        check("lit_frozen_pc", pc, 32'h0040_0002);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("lit_fault_cleared", {31'b0, fetch_fault}, 32'h0);

        // run off the end of the text segment
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_00C4);
        run(1);
        check("lit_word49", if_id_instruction, 32'h2400_0031);
        run(1);
        check("lit_word50", if_id_instruction, 32'h2400_0032);
        check("lit_end_pc", pc, 32'h0040_00CC);
        run(1);
        check("lit_end_fault", {31'b0, fetch_fault}, 32'h1);
        check("lit_end_valid", {31'b0, if_id_valid}, 32'h0);
        run(2);

        // reset while stalled and faulted
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        // below the text base
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h003F_FFFC);
        run(2);
        check("lit_below_fault", {31'b0, fetch_fault}, 32'h1);
        // wrap past 2^32
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run(2);
        check("lit_wrap_fault", {31'b0, fetch_fault}, 32'h1);
        // reset mid-stall restores reset values, then fetch restarts at word 0
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        run(2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("lit_rst_stall_pc", pc, 32'h0040_0000);
        run(1);
        check("lit_restart_ins", if_id_instruction, 32'h2008_0005);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
